clk_div_gen: RTL
================

// Module: clk_div_gen
// PURPOSE
//  Parametrised multi-channel clock-enable/divided-clock generator for team_08 peripherals
//  (LCD pixel strobe, 10 kHz scan tick, ...), driven from one system clock.
//  Each channel has a run-time programmable divisor, a glitch-free update rule and a
//  square-wave output. A lock sequencer asserts `locked` once all channels are stable.
//  Sits between the board clock input and every block that needs a slower timebase.
// PARAMETERS
//  NUM_CH       2     number of independent divider channels
//  CNT_W        16    divisor / counter width in bits
//  LOCK_CYCLES  16    clk cycles of stable running required before locked=1 (>=1)
//  DIV_RST      4     divisor value loaded into every channel at reset
// PORTS
//  clk       in   1             system clock; the only clock
//  nrst      in   1             synchronous active-low reset
//  en        in   1             global run enable; 0 freezes counters and outputs
//  cfg_we    in   1             config write strobe, 1-cycle
//  cfg_ch    in   $clog2(NUM_CH) target channel of cfg write (values >= NUM_CH ignored)
//  cfg_div   in   CNT_W         new divisor D for the channel
//  ch_tick   out  NUM_CH        1-cycle enable pulse per channel, period D+1 cycles
//  ch_clk    out  NUM_CH        50% square wave per channel, toggles on each tick
//  locked    out  1             all channels running with applied config for LOCK_CYCLES
// BEHAVIOUR
//  - Reset (nrst=0 sampled at posedge): all counters=0, active div=shadow div=DIV_RST,
//    ch_tick=0, ch_clk=0, lock counter=0, locked=0. No other reset source.
//  - Channel counter: when en=1, cnt==active_div -> cnt<=0, tick registered high next
//    cycle, ch_clk toggles in same cycle as tick; else cnt<=cnt+1. D=0 -> tick every cycle,
//    ch_clk period 2 cycles. Counter width CNT_W, never wraps past active_div.
//  - Outputs registered: tick is high exactly the cycle after terminal count, 1 cycle wide.
//  - en=0: counters, ch_clk hold; ch_tick forced 0; lock counter cleared; locked<=0.
//  - Config: cfg_we writes shadow div of cfg_ch. Shadow copied to active div only at the
//    channel's terminal count (no short/long glitch periods). Write and terminal count in
//    same cycle: new value becomes active at that terminal count. Two writes before
//    terminal count: last wins.
//  - Lock FSM states: UNLOCKED -> COUNTING -> LOCKED.
//    UNLOCKED: en=1 and no shadow!=active pending -> COUNTING, lock cnt=0.
//    COUNTING: lock cnt++ per cycle; reaching LOCK_CYCLES-1 -> LOCKED (locked=1 next cycle).
//    Any state: en=0 or any pending shadow!=active -> UNLOCKED, locked=0 same next cycle.
//    locked never glitches high during a divisor change.
//  - Reset mid-operation overrides everything on that edge; outputs at reset values next cycle.
// CONFIGURATION
//  CLK_DIV_GEN_SYNC_EN defined: extra input `sync` (1 bit). sync=1 with en=1 clears all
//    channel counters to 0 and ch_clk to 0 that cycle, applies all pending shadow divs
//    immediately, drops locked and restarts lock FSM -> channels phase-aligned.
//    sync has priority over terminal count and cfg_we in the same cycle (cfg_we still
//    writes shadow, applied at next terminal count).
//  Not defined: no `sync` port; channels align only via reset.
// TESTING
//  1 Reset, en=1, DIV_RST=4 -> ch_tick every 5 cycles on both channels, ch_clk period 10,
//    locked rises exactly LOCK_CYCLES cycles after en.
//  2 D=0 on ch0 -> ch_tick[0] constantly 1 after first tick, ch_clk[0] toggles every cycle.
//  3 Write D=9 to ch1 mid-period -> current period stays 5, then 10-cycle periods; locked
//    drops on write, reasserts LOCK_CYCLES after apply.
//  4 en low for 7 cycles mid-count -> ticks 0, counter/ch_clk held, locked 0, resumes
//    exactly where it stopped; locked after LOCK_CYCLES.
//  5 nrst low during pending update -> all outputs 0, div back to 4, pending write lost.
//  6 (SYNC_EN) ch0 D=3, ch1 D=7, pulse sync -> both ch_tick fire together 4 cycles later
//    for ch0, 8 for ch1, every 8th cycle coincident.

Source files
------------

// File: rtl/clk_div_gen.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_gen
//  Purpose  : Multi-channel clock-enable / divided-clock generator. Each
//             channel counts 0..D on the system clock, emits a one-cycle
//             tick at terminal count and toggles a square-wave output on
//             every tick. Divisor updates are staged in a shadow register
//             and only take effect at the channel's terminal count, so no
//             shortened or stretched period ever appears. A lock sequencer
//             raises `locked` once every channel has run with its applied
//             divisor for LOCK_CYCLES cycles.
//  Optional : CLK_DIV_GEN_SYNC_EN adds a `sync` input that phase-aligns all
//             channels and applies pending divisors immediately.
//  Ports    : clk      - system clock
//             nrst     - synchronous active-low reset
//             en       - global run enable (0 freezes counters / ch_clk)
//             cfg_we   - one-cycle divisor write strobe
//             cfg_ch   - channel selected by cfg_we
//             cfg_div  - new divisor D (period D+1 cycles)
//             sync     - phase-align strobe (CLK_DIV_GEN_SYNC_EN only)
//             ch_tick  - per-channel one-cycle enable pulse
//             ch_clk   - per-channel 50% square wave
//             locked   - all channels stable for LOCK_CYCLES cycles
//  Revision : 1.0 - initial release
// ============================================================================
module clk_div_gen #(
    parameter  int NUM_CH      = 2,
    parameter  int CNT_W       = 16,
    parameter  int LOCK_CYCLES = 16,
    parameter  int DIV_RST     = 4,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
`ifdef CLK_DIV_GEN_SYNC_EN
    input  logic              sync,
`endif
    output logic [NUM_CH-1:0] ch_tick,
    output logic [NUM_CH-1:0] ch_clk,
    output logic              locked
);

    localparam int LC_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_COUNTING = 2'd1,
        ST_LOCKED   = 2'd2
    } lock_state_t;

    // Per-channel state
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0][CNT_W-1:0] act_div_q, act_div_d;
    logic [NUM_CH-1:0][CNT_W-1:0] shd_div_q, shd_div_d;
    logic [NUM_CH-1:0]            tick_q, tick_d;
    logic [NUM_CH-1:0]            sqw_q, sqw_d;

    // Lock sequencer state
    lock_state_t                  state_q, state_d;
    logic [LC_W-1:0]              lock_cnt_q, lock_cnt_d;
    logic                         locked_q, locked_d;

    logic [NUM_CH-1:0]            w_wr;
    logic                         w_pending;
    logic                         w_sync;

`ifdef CLK_DIV_GEN_SYNC_EN
    assign w_sync = sync & en;
`else
    assign w_sync = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Channel datapath
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d     = cnt_q;
        act_div_d = act_div_q;
        shd_div_d = shd_div_q;
        tick_d    = '0;
        sqw_d     = sqw_q;
        w_wr      = '0;
        w_pending = 1'b0;

        for (int i = 0; i < NUM_CH; i++) begin
            w_wr[i] = cfg_we && (cfg_ch == CH_W'(i));
            // Pending uses the registered copies: the lock FSM reacts the
            // cycle after a write lands in the shadow register.
            if (shd_div_q[i] != act_div_q[i]) begin
                w_pending = 1'b1;
            end
        end

        for (int i = 0; i < NUM_CH; i++) begin
            if (w_wr[i]) begin
                shd_div_d[i] = cfg_div;
            end

            if (w_sync) begin
                // Alignment applies the previously staged divisor; a write in
                // this same cycle waits for the next terminal count.
                cnt_d[i]     = '0;
                sqw_d[i]     = 1'b0;
                act_div_d[i] = shd_div_q[i];
            end else if (en) begin
                if (cnt_q[i] == act_div_q[i]) begin
                    cnt_d[i]     = '0;
                    tick_d[i]    = 1'b1;
                    sqw_d[i]     = ~sqw_q[i];
                    // A write coinciding with terminal count is taken now.
                    act_div_d[i] = w_wr[i] ? cfg_div : shd_div_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Lock sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;

        if (!en || w_pending || w_sync) begin
            state_d    = ST_UNLOCKED;
            lock_cnt_d = '0;
        end else begin
            case (state_q)
                ST_UNLOCKED: begin
                    state_d    = ST_COUNTING;
                    lock_cnt_d = '0;
                end
                ST_COUNTING: begin
                    if (lock_cnt_q == LC_W'(LOCK_CYCLES - 1)) begin
                        state_d = ST_LOCKED;
                    end else begin
                        lock_cnt_d = lock_cnt_q + LC_W'(1);
                    end
                end
                ST_LOCKED: begin
                    state_d = ST_LOCKED;
                end
                default: begin
                    state_d    = ST_UNLOCKED;
                    lock_cnt_d = '0;
                end
            endcase
        end

        locked_d = (state_d == ST_LOCKED);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt_q      <= '0;
            act_div_q  <= {NUM_CH{CNT_W'(DIV_RST)}};
            shd_div_q  <= {NUM_CH{CNT_W'(DIV_RST)}};
            tick_q     <= '0;
            sqw_q      <= '0;
            state_q    <= ST_UNLOCKED;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            act_div_q  <= act_div_d;
            shd_div_q  <= shd_div_d;
            tick_q     <= tick_d;
            sqw_q      <= sqw_d;
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
        end
    end

    assign ch_tick = tick_q;
    assign ch_clk  = sqw_q;
    assign locked  = locked_q;

endmodule
`default_nettype wire
